// File: rtl/sdram_read_fifo.sv
// First-word-fall-through FIFO between the SDRAM read engine and the wishbone read path.
// fifo_full asserts FULL_MARGIN entries early so the engine can finish the word in flight.
module sdram_read_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_BITS  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_write,
  output logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_pop,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] FULL_LVL  = (DEPTH_BITS + 1)'(DEPTH - FULL_MARGIN);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_empty;
  logic w_at_depth;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty    = (r_count == '0);
  assign w_at_depth = (r_count == DEPTH_CNT);
  assign w_pop_ok   = rd_pop && !w_empty && !flush;
  // At DEPTH a same-cycle pop frees the slot, so the push still lands.
  assign w_push_ok  = fifo_write && (!w_at_depth || rd_pop) && !flush;

  // NOTE: storage is deliberately left out of reset; rd_data is only meaningful while rd_valid=1.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= fifo_data;
    end
  end

  // NOTE: all state updates use <= so every read here sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (fifo_write && w_at_depth && !rd_pop) begin
        r_overflow <= 1'b1;
      end
      if (rd_pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign rd_valid  = !w_empty;
  assign fifo_full = (r_count >= FULL_LVL);
  assign rd_data   = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_sdram_read_fifo.sv
// Directed bench for sdram_read_fifo: a queue model checked every cycle plus literal expectations.
module tb_sdram_read_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] fifo_data;
  logic        fifo_write;
  logic        fifo_full;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_pop;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_q[$];
  bit          m_ov = 1'b0;
  bit          m_un = 1'b0;

  sdram_read_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_data  (fifo_data),
    .fifo_write (fifo_write),
    .fifo_full  (fifo_full),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_pop     (rd_pop),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a pop frees its slot before the push is considered; a full FIFO holds 16 words.
  always @(posedge clk) begin
    if (rst || flush) begin
      m_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (rd_pop) begin
        if (m_q.size() == 0) m_un = 1'b1;
        else void'(m_q.pop_front());
      end
      if (fifo_write) begin
        if (m_q.size() < 16) m_q.push_back(fifo_data);
        else m_ov = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count", 32'(count), 32'(m_q.size()));
      check("m_valid", 32'(rd_valid), 32'(m_q.size() != 0));
      check("m_full", 32'(fifo_full), 32'(m_q.size() >= 14));
      check("m_overflow", 32'(overflow), 32'(m_ov));
      check("m_underflow", 32'(underflow), 32'(m_un));
      if (m_q.size() != 0) check("m_rd_data", rd_data, m_q[0]);
    end
  end

  task automatic step(input bit w, input logic [31:0] d, input bit p, input bit f);
    fifo_write = w;
    fifo_data  = d;
    rd_pop     = p;
    flush      = f;
    @(posedge clk);
    @(negedge clk);
    fifo_write = 1'b0;
    rd_pop     = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_out;
    rst = 1'b1; flush = 1'b0; fifo_write = 1'b0; fifo_data = '0; rd_pop = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_full", 32'(fifo_full), 32'd0);
    check("reset_flags", {30'd0, overflow, underflow}, 32'd0);

    // Basic ordering and one-cycle fall-through
    step(1, 32'h11111111, 0, 0);
    check("fwft_first", rd_data, 32'h11111111);
    step(1, 32'h22222222, 0, 0);
    step(1, 32'h33333333, 0, 0);
    check("three_count", 32'(count), 32'd3);
    check("three_valid", 32'(rd_valid), 32'd1);
    check("three_head", rd_data, 32'h11111111);
    step(0, '0, 1, 0);
    check("pop1_head", rd_data, 32'h22222222);
    step(0, '0, 1, 0);
    check("pop2_head", rd_data, 32'h33333333);
    step(0, '0, 1, 0);
    check("drained_count", 32'(count), 32'd0);
    check("drained_valid", 32'(rd_valid), 32'd0);

    // Threshold and fill to depth
    for (int i = 0; i < 13; i++) step(1, 32'h100 + 32'(i), 0, 0);
    check("13_not_full", 32'(fifo_full), 32'd0);
    step(1, 32'h10D, 0, 0);
    check("14_full", 32'(fifo_full), 32'd1);
    step(1, 32'h10E, 0, 0);
    step(1, 32'h10F, 0, 0);
    check("16_count", 32'(count), 32'd16);
    check("16_no_ovf", 32'(overflow), 32'd0);

    // Dropped push at depth
    step(1, 32'hDEADBEEF, 0, 0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain", rd_data, 32'h100 + 32'(i));
      step(0, '0, 1, 0);
    end
    check("ovf_drained", 32'(count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    step(0, '0, 0, 1);
    check("flush_ovf", 32'(overflow), 32'd0);

    // Push with pop at depth
    for (int i = 0; i < 16; i++) step(1, 32'h200 + 32'(i), 0, 0);
    step(1, 32'hCAFEF00D, 1, 0);
    check("pp_count", 32'(count), 32'd16);
    check("pp_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 15; i++) step(0, '0, 1, 0);
    check("pp_tail", rd_data, 32'hCAFEF00D);
    step(0, '0, 0, 1);

    // Push with pop on empty
    step(1, 32'hA5A5A5A5, 1, 0);
    check("un_flag", 32'(underflow), 32'd1);
    check("un_count", 32'(count), 32'd1);
    check("un_data", rd_data, 32'hA5A5A5A5);
    step(0, '0, 0, 1);

    // Streaming with pointer wrap
    exp_out = 32'h300;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid) begin
        check("stream_out", rd_data, exp_out);
        exp_out++;
        step(1, 32'h300 + 32'(i), 1, 0);
      end else begin
        step(1, 32'h300 + 32'(i), 0, 0);
      end
    end
    check("stream_last", rd_data, 32'h313);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(1, 32'h400, 0, 0);
    check("pre_flush_un", 32'(underflow), 32'd1);
    step(1, 32'h401, 0, 1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(rd_valid), 32'd0);
    check("flush_ovf2", 32'(overflow), 32'd0);
    check("flush_un", 32'(underflow), 32'd0);
    step(0, '0, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
